// File: rtl/reg_exec_unit_pkg.sv
// Shared opcodes, FSM encoding and width helper for the execute stage.
package exec_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [OP_W-1:0] OP_AND = 3'd2;
  localparam logic [OP_W-1:0] OP_NOT = 3'd3;
  localparam logic [OP_W-1:0] OP_MOV = 3'd4;
  localparam logic [OP_W-1:0] OP_CLR = 3'd5;
  localparam logic [OP_W-1:0] OP_MUL = 3'd6;
  localparam logic [OP_W-1:0] OP_NOP = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_MULT  = 3'd3,
    S_WB    = 3'd4
  } state_t;

  // Address width for n entries, never narrower than one bit.
  function automatic int unsigned addrWidth(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_exec_unit_if.sv
// Request handshake plus register-file read/write port of the execute stage.
interface reg_exec_unit_if #(
  parameter int unsigned WordLen   = 16,
  parameter int unsigned WordCount = 8
);
  localparam int unsigned AW = exec_pkg::addrWidth(WordCount);

  logic                      start;
  logic [exec_pkg::OP_W-1:0] op;
  logic [AW-1:0]             srcAdr;
  logic [AW-1:0]             dstAdr;
  logic [WordLen-1:0]        readData0;
  logic [WordLen-1:0]        readData1;
  logic [AW-1:0]             readAdr;
  logic [AW-1:0]             writeAdr;
  logic [WordLen-1:0]        writeData;
  logic                      regWrite;
  logic                      sclr;
  logic                      busy;
  logic                      done;
  logic                      zero;
  logic                      carry;

  modport master (
    output start, op, srcAdr, dstAdr, readData0, readData1,
    input  readAdr, writeAdr, writeData, regWrite, sclr, busy, done, zero, carry
  );

  modport slave (
    input  start, op, srcAdr, dstAdr, readData0, readData1,
    output readAdr, writeAdr, writeData, regWrite, sclr, busy, done, zero, carry
  );
endinterface

// File: rtl/reg_exec_unit_mul.sv
// Sequential unsigned shift-add multiplier keeping the low WordLen product bits.
module shift_add_mul
  import exec_pkg::*;
#(
  parameter int unsigned WordLen = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [WordLen-1:0] a,
  input  logic [WordLen-1:0] b,
  output logic [WordLen-1:0] product,
  output logic               last
);
  localparam int unsigned CW = addrWidth(WordLen);

  logic [WordLen-1:0] acc;
  logic [WordLen-1:0] mcand;
  logic [WordLen-1:0] mplier;
  logic [CW-1:0]      cnt;
  logic               running;

  // Accumulator including the step in progress, so the final product is ready with last.
  assign product = acc + (mplier[0] ? mcand : '0);
  assign last    = running && (cnt == CW'(WordLen - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      running <= 1'b0;
    end else if (load) begin
      acc     <= '0;
      mcand   <= a;
      mplier  <= b;
      cnt     <= '0;
      running <= 1'b1;
    end else if (running) begin
      acc     <= product;
      mcand   <= mcand << 1;
      mplier  <= mplier >> 1;
      cnt     <= cnt + CW'(1);
      if (last) running <= 1'b0;
    end
  end
endmodule

// File: rtl/reg_exec_unit.sv
// Multi-cycle execute stage: fetch R0/Rs, compute (incl. shift-add multiply), write back.
module reg_exec_unit
  import exec_pkg::*;
#(
  parameter int unsigned WordLen   = 16,
  parameter int unsigned WordCount = 8
) (
  input logic             clk,
  input logic             rst,
  reg_exec_unit_if.slave  bus
);
  localparam int unsigned AW = addrWidth(WordCount);

  state_t             state, stateNext;
  logic [OP_W-1:0]    opQ;
  logic [AW-1:0]      srcQ, dstQ;
  logic [WordLen-1:0] a, b, y;
  logic               busyQ, doneQ, regWriteQ, sclrQ, zeroQ, carryQ;
  logic               busyNext, doneNext, regWriteNext, sclrNext;
  logic [WordLen:0]   sum, diff;
  logic [WordLen-1:0] aluY;
  logic               writesOp, mulLoad, mulLast;
  logic [WordLen-1:0] mulProduct;

  assign writesOp = (opQ != OP_CLR) && (opQ != OP_NOP);
  assign mulLoad  = (state == S_FETCH) && (opQ == OP_MUL);
  assign sum      = {1'b0, a} + {1'b0, b};
  assign diff     = {1'b0, a} - {1'b0, b};

  shift_add_mul #(.WordLen(WordLen)) u_mul (
    .clk    (clk),
    .rst    (rst),
    .load   (mulLoad),
    .a      (bus.readData0),
    .b      (bus.readData1),
    .product(mulProduct),
    .last   (mulLast)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= stateNext;
  end

  // Next state plus next values of the registered strobes.
  always_comb begin
    stateNext = state;
    case (state)
      S_IDLE:  if (bus.start) stateNext = S_FETCH;
      S_FETCH: stateNext = (opQ == OP_MUL) ? S_MULT : S_EXEC;
      S_EXEC:  stateNext = S_WB;
      S_MULT:  if (mulLast) stateNext = S_WB;
      S_WB:    stateNext = S_IDLE;
      default: stateNext = S_IDLE;
    endcase
    busyNext     = (stateNext != S_IDLE);
    doneNext     = (stateNext == S_WB);
    regWriteNext = doneNext && writesOp;
    sclrNext     = doneNext && (opQ == OP_CLR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busyQ     <= 1'b0;
      doneQ     <= 1'b0;
      regWriteQ <= 1'b0;
      sclrQ     <= 1'b0;
    end else begin
      busyQ     <= busyNext;
      doneQ     <= doneNext;
      regWriteQ <= regWriteNext;
      sclrQ     <= sclrNext;
    end
  end

  always_comb begin
    aluY = '0;
    case (opQ)
      OP_ADD:  aluY = sum[WordLen-1:0];
      OP_SUB:  aluY = diff[WordLen-1:0];
      OP_AND:  aluY = a & b;
      OP_NOT:  aluY = ~b;
      OP_MOV:  aluY = b;
      default: aluY = '0;
    endcase
  end

  // Request fields, operand latches, result and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opQ    <= '0;
      srcQ   <= '0;
      dstQ   <= '0;
      a      <= '0;
      b      <= '0;
      y      <= '0;
      zeroQ  <= 1'b0;
      carryQ <= 1'b0;
    end else begin
      if (state == S_IDLE && bus.start) begin
        opQ  <= bus.op;
        srcQ <= bus.srcAdr;
        dstQ <= bus.dstAdr;
      end
      if (state == S_FETCH) begin
        a <= bus.readData0;
        b <= bus.readData1;
      end
      if (state == S_EXEC && opQ != OP_NOP) begin
        y     <= aluY;
        zeroQ <= (aluY == '0);
        if (opQ == OP_ADD) carryQ <= sum[WordLen];
        if (opQ == OP_SUB) carryQ <= diff[WordLen];
      end
      if (state == S_MULT && mulLast) begin
        y     <= mulProduct;
        zeroQ <= (mulProduct == '0);
      end
    end
  end

  assign bus.readAdr   = srcQ;
  assign bus.writeAdr  = dstQ;
  assign bus.writeData = y;
  assign bus.regWrite  = regWriteQ;
  assign bus.sclr      = sclrQ;
  assign bus.busy      = busyQ;
  assign bus.done      = doneQ;
  assign bus.zero      = zeroQ;
  assign bus.carry     = carryQ;
endmodule

// File: tb/tb_reg_exec_unit.sv
// Bench for reg_exec_unit: register-file environment, behavioural model, per-cycle compare.
module tb_reg_exec_unit;
  localparam int unsigned W  = 16;
  localparam int unsigned N  = 8;
  localparam int unsigned AW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_exec_unit_if #(.WordLen(W), .WordCount(N)) bus ();

  reg_exec_unit #(.WordLen(W), .WordCount(N)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Register file environment: backdoor preload port plus the DUT's write port.
  logic [W-1:0]  rf [N];
  logic          preEn  = 1'b0;
  logic [AW-1:0] preAdr = '0;
  logic [W-1:0]  preVal = '0;
  always @(posedge clk) begin
    if (preEn)             rf[preAdr]       <= preVal;
    else if (bus.regWrite) rf[bus.writeAdr] <= bus.writeData;
    else if (bus.sclr)     rf[bus.writeAdr] <= '0;
  end
  assign bus.readData0 = rf[0];
  assign bus.readData1 = rf[bus.readAdr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Request mailbox written by the stimulus, consumed by the model.
  int            reqId = 0;
  int            reqC0 = 0;
  logic [2:0]    reqOp = '0;
  logic [AW-1:0] reqSrc = '0, reqDst = '0, reqLitWa = '0;
  logic          reqLit = 1'b0, reqLitWdOn = 1'b0, reqLitZ = 1'b0, reqLitC = 1'b0;
  logic [W-1:0]  reqLitWd = '0;

  // Model state, owned by the compare process.
  int            checks = 0, errors = 0, seenId = 0, c0 = 0, lat = 0;
  logic          pend = 1'b0, fresh = 1'b1, mZ = 1'b0, mC = 1'b0, nC = 1'b0;
  logic          mWrites = 1'b0, mClr = 1'b0, mFlagUpd = 1'b0, mCarryUpd = 1'b0;
  logic          isWb = 1'b0, isAct = 1'b0;
  logic          litOn = 1'b0, litWdOn = 1'b0, litZ = 1'b0, litC = 1'b0;
  logic [W-1:0]  litWd = '0;
  logic [AW-1:0] litWa = '0;
  logic [2:0]    mOp = '0;
  logic [AW-1:0] mSrc = '0, mDst = '0;
  logic [W-1:0]  mY = '0, opA = '0, opB = '0;
  logic [W-1:0]  mRf [N];
  logic [16:0]   s17;
  logic [31:0]   p32;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_busy",     32'(bus.busy),      32'd0);
      chk("rst_done",     32'(bus.done),      32'd0);
      chk("rst_regWrite", 32'(bus.regWrite),  32'd0);
      chk("rst_sclr",     32'(bus.sclr),      32'd0);
      chk("rst_zero",     32'(bus.zero),      32'd0);
      chk("rst_carry",    32'(bus.carry),     32'd0);
      chk("rst_readAdr",  32'(bus.readAdr),   32'd0);
      chk("rst_writeAdr", 32'(bus.writeAdr),  32'd0);
      chk("rst_writeData",32'(bus.writeData), 32'd0);
      pend = 1'b0; mZ = 1'b0; mC = 1'b0; mSrc = '0; fresh = 1'b1; seenId = reqId;
    end else begin
      if (preEn) mRf[preAdr] = preVal;
      if (reqId != seenId) begin
        seenId = reqId; pend = 1'b1; fresh = 1'b0;
        c0 = reqC0; mOp = reqOp; mSrc = reqSrc; mDst = reqDst;
        litOn = reqLit; litWdOn = reqLitWdOn; litWd = reqLitWd;
        litZ = reqLitZ; litC = reqLitC; litWa = reqLitWa;
        opA = mRf[0]; opB = mRf[mSrc];
        case (mOp)
          3'd0: begin s17 = 17'(opA) + 17'(opB); mY = s17[15:0]; nC = s17[16]; end
          3'd1: begin mY = opA - opB; nC = (opA < opB); end
          3'd2: mY = opA & opB;
          3'd3: mY = ~opB;
          3'd4: mY = opB;
          3'd5: mY = '0;
          3'd6: begin p32 = 32'(opA) * 32'(opB); mY = p32[15:0]; end
          default: ;
        endcase
        lat       = (mOp == 3'd6) ? 18 : 3;
        mWrites   = (mOp <= 3'd4) || (mOp == 3'd6);
        mClr      = (mOp == 3'd5);
        mFlagUpd  = (mOp != 3'd7);
        mCarryUpd = (mOp <= 3'd1);
      end
      isAct = pend && (cyc >= c0) && (cyc <= c0 + lat - 1);
      isWb  = pend && (cyc == c0 + lat - 1);
      if (isWb && mFlagUpd) begin
        mZ = (mY == '0);
        if (mCarryUpd) mC = nC;
      end
      chk("busy",     32'(bus.busy),     32'(isAct));
      chk("done",     32'(bus.done),     32'(isWb));
      chk("regWrite", 32'(bus.regWrite), 32'(isWb && mWrites));
      chk("sclr",     32'(bus.sclr),     32'(isWb && mClr));
      chk("readAdr",  32'(bus.readAdr),  32'(mSrc));
      chk("zero",     32'(bus.zero),     32'(mZ));
      chk("carry",    32'(bus.carry),    32'(mC));
      if (fresh) begin
        chk("idle_writeAdr",  32'(bus.writeAdr),  32'd0);
        chk("idle_writeData", 32'(bus.writeData), 32'd0);
      end
      if (isWb) begin
        chk("writeAdr", 32'(bus.writeAdr), 32'(mDst));
        if (mWrites || mClr) chk("writeData", 32'(bus.writeData), 32'(mY));
        if (mWrites) mRf[mDst] = mY;
        if (mClr)    mRf[mDst] = '0;
        if (litOn) begin
          if (litWdOn) chk("lit_writeData", 32'(bus.writeData), 32'(litWd));
          chk("lit_writeAdr", 32'(bus.writeAdr), 32'(litWa));
          chk("lit_zero",     32'(bus.zero),     32'(litZ));
          chk("lit_carry",    32'(bus.carry),    32'(litC));
        end
        pend = 1'b0;
      end
    end
  end

  task automatic preload(input logic [AW-1:0] adr, input logic [W-1:0] val);
    preEn = 1'b1; preAdr = adr; preVal = val;
    @(posedge clk); #1;
    preEn = 1'b0;
  endtask

  // Starts one operation and returns in the first IDLE cycle after its WB.
  task automatic issue(input logic [2:0] op, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                       input logic glitch, input logic lit, input logic litWdOnArg,
                       input logic [W-1:0] wd, input logic z, input logic c, input logic [AW-1:0] wa);
    int l = (op == 3'd6) ? 18 : 3;
    bus.start = 1'b1; bus.op = op; bus.srcAdr = src; bus.dstAdr = dst;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op = 3'($urandom); bus.srcAdr = 3'($urandom); bus.dstAdr = 3'($urandom);
    reqC0 = cyc; reqOp = op; reqSrc = src; reqDst = dst;
    reqLit = lit; reqLitWdOn = litWdOnArg; reqLitWd = wd; reqLitZ = z; reqLitC = c; reqLitWa = wa;
    reqId++;
    if (glitch) begin
      @(posedge clk); #1;
      bus.start = 1'b1; bus.op = 3'($urandom); bus.srcAdr = 3'($urandom); bus.dstAdr = 3'($urandom);
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (l - 2) @(posedge clk);
    end else begin
      repeat (l) @(posedge clk);
    end
    #1;
  endtask

  initial begin
    bus.start = 1'b0; bus.op = '0; bus.srcAdr = '0; bus.dstAdr = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < N; i++) preload(3'(i), 16'($urandom));

    preload(3'd0, 16'd5); preload(3'd3, 16'd7);
    issue(3'd0, 3'd3, 3'd0, 1'b0, 1'b1, 1'b1, 16'd12, 1'b0, 1'b0, 3'd0);
    preload(3'd0, 16'd3); preload(3'd1, 16'd5);
    issue(3'd1, 3'd1, 3'd2, 1'b0, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b1, 3'd2);
    preload(3'd0, 16'd9); preload(3'd1, 16'd9);
    issue(3'd1, 3'd1, 3'd2, 1'b0, 1'b1, 1'b1, 16'd0, 1'b1, 1'b0, 3'd2);
    preload(3'd0, 16'hFFFF); preload(3'd2, 16'd1);
    issue(3'd0, 3'd2, 3'd3, 1'b0, 1'b1, 1'b1, 16'd0, 1'b1, 1'b1, 3'd3);
    issue(3'd5, 3'd0, 3'd5, 1'b0, 1'b1, 1'b1, 16'd0, 1'b1, 1'b1, 3'd5);
    preload(3'd0, 16'd300); preload(3'd4, 16'd250);
    issue(3'd6, 3'd4, 3'd6, 1'b0, 1'b1, 1'b1, 16'd9464, 1'b0, 1'b1, 3'd6);
    preload(3'd0, 16'd1); preload(3'd1, 16'd2);
    issue(3'd0, 3'd1, 3'd7, 1'b1, 1'b1, 1'b1, 16'd3, 1'b0, 1'b0, 3'd7);
    issue(3'd7, 3'd0, 3'd1, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 3'd1);

    // Reset during the WB cycle of an ADD: the write must not land.
    preload(3'd0, 16'h0010); preload(3'd1, 16'h0020); preload(3'd4, 16'h1234);
    bus.start = 1'b1; bus.op = 3'd0; bus.srcAdr = 3'd1; bus.dstAdr = 3'd4;
    @(posedge clk); #1;
    bus.start = 1'b0;
    reqC0 = cyc; reqOp = 3'd0; reqSrc = 3'd1; reqDst = 3'd4; reqLit = 1'b0; reqId++;
    repeat (2) @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    issue(3'd4, 3'd4, 3'd0, 1'b0, 1'b1, 1'b1, 16'h1234, 1'b0, 1'b0, 3'd0);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) == 0)
        preload(3'($urandom), ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom));
      issue(3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom_range(0, 1)),
            1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 3'd0);
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
